// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared types for the pipeline stall/flush sequencer: sequencer states,
//   register-specifier width, and the bundle of per-stage control strobes
//   with constructors for the three recurring control patterns.
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   localparam int REG_W = 5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_IMISS = 2'd1,
      ST_DMISS = 2'd2,
      ST_ERR   = 2'd3
   } state_e;

   typedef struct packed {
      logic pc_write;
      logic pc_sel;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_write;
      logic id_ex_flush;
      logic ex_mem_write;
      logic ex_mem_flush;
      logic mem_wb_flush;
      logic i_abort;
   } ctrl_t;

   // Free-running pipeline: every stage advances, nothing flushed.
   function automatic ctrl_t ctrl_run();
      ctrl_t c;
      c              = '0;
      c.pc_write     = 1'b1;
      c.if_id_write  = 1'b1;
      c.id_ex_write  = 1'b1;
      c.ex_mem_write = 1'b1;
      return c;
   endfunction

   // Reset / error: nothing advances, every stage register holds a bubble.
   function automatic ctrl_t ctrl_halt();
      ctrl_t c;
      c              = '0;
      c.if_id_flush  = 1'b1;
      c.id_ex_flush  = 1'b1;
      c.ex_mem_flush = 1'b1;
      c.mem_wb_flush = 1'b1;
      return c;
   endfunction

   // D-miss freeze: PC..ex_mem hold; mem_wb gets a bubble unless the fill
   // lands this cycle, in which case the load result is captured.
   function automatic ctrl_t ctrl_freeze(input logic wb_flush);
      ctrl_t c;
      c              = '0;
      c.mem_wb_flush = wb_flush;
      return c;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
//   Bundle between the stall/flush sequencer and the datapath.
//   Hazard inputs : ifIdRs, ifIdRt, idExRt, idExMemRead, memPcSrc,
//                   dMiss, dReady, iMiss, iReady
//   Control outs  : pcWrite, pcSel, ifIdWrite/Flush, idExWrite/Flush,
//                   exMemWrite/Flush, memWbFlush, iAbort, err
//   Counters      : stallCnt, flushCnt (CNT_W bits)
//   master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if import pipeline_ctrl_pkg::*; #(
   parameter int CNT_W = 32
);
   logic [REG_W-1:0] ifIdRs;
   logic [REG_W-1:0] ifIdRt;
   logic [REG_W-1:0] idExRt;
   logic             idExMemRead;
   logic             memPcSrc;
   logic             dMiss;
   logic             dReady;
   logic             iMiss;
   logic             iReady;

   logic             pcWrite;
   logic             pcSel;
   logic             ifIdWrite;
   logic             ifIdFlush;
   logic             idExWrite;
   logic             idExFlush;
   logic             exMemWrite;
   logic             exMemFlush;
   logic             memWbFlush;
   logic             iAbort;
   logic             err;
   logic [CNT_W-1:0] stallCnt;
   logic [CNT_W-1:0] flushCnt;

   modport master (
      input  ifIdRs, ifIdRt, idExRt, idExMemRead, memPcSrc,
             dMiss, dReady, iMiss, iReady,
      output pcWrite, pcSel, ifIdWrite, ifIdFlush, idExWrite, idExFlush,
             exMemWrite, exMemFlush, memWbFlush, iAbort, err,
             stallCnt, flushCnt
   );

   modport slave (
      output ifIdRs, ifIdRt, idExRt, idExMemRead, memPcSrc,
             dMiss, dReady, iMiss, iReady,
      input  pcWrite, pcSel, ifIdWrite, ifIdFlush, idExWrite, idExFlush,
             exMemWrite, exMemFlush, memWbFlush, iAbort, err,
             stallCnt, flushCnt
   );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_hazard_detect
//   Combinational load-use detector: the load in EX writes a register that
//   the instruction in ID reads. r0 is never a real dependency.
//   Inputs : if_id_rs, if_id_rt, id_ex_rt, id_ex_mem_read
//   Output : load_use
// ---------------------------------------------------------------------------
module pipeline_ctrl_hazard_detect import pipeline_ctrl_pkg::*; (
   input  logic [REG_W-1:0] if_id_rs,
   input  logic [REG_W-1:0] if_id_rt,
   input  logic [REG_W-1:0] id_ex_rt,
   input  logic             id_ex_mem_read,
   output logic             load_use
);

   always_comb begin
      load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                 ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. Mealy decode of
//   state + hazard inputs with fixed priority:
//     ERR > D-miss > MEM branch redirect > load-use > I-miss.
//   A miss state that lasts MISS_TIMEOUT cycles without its fill parks the
//   sequencer in ERR until reset. Saturating counters track stall cycles
//   (pcWrite=0) and taken redirects.
//   Ports: clock, reset_n (async, active low), bus (pipeline_ctrl_if.master)
// ---------------------------------------------------------------------------
module pipeline_ctrl import pipeline_ctrl_pkg::*; #(
   parameter int MISS_TIMEOUT = 255,
   parameter int CNT_W        = 32
) (
   input  logic            clock,
   input  logic            reset_n,
   pipeline_ctrl_if.master bus
);

   localparam int              TMR_W     = $clog2(MISS_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MISS_TIMEOUT);

   state_e           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d, timer_inc;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             load_use;
   logic             branch_taken;
   logic             miss_expired;
   ctrl_t            ctrl;
   ctrl_t            ctrl_out;

   pipeline_ctrl_hazard_detect u_hazard (
      .if_id_rs       (bus.ifIdRs),
      .if_id_rt       (bus.ifIdRt),
      .id_ex_rt       (bus.idExRt),
      .id_ex_mem_read (bus.idExMemRead),
      .load_use       (load_use)
   );

   // timer_q counts completed miss cycles; this cycle is the last one allowed
   // when counting it reaches the limit. timer_inc never exceeds the limit.
   assign timer_inc    = timer_q + TMR_W'(1);
   assign miss_expired = (timer_inc == TMR_LIMIT);

   always_comb begin
      ctrl         = ctrl_run();
      state_d      = state_q;
      timer_d      = timer_q;
      branch_taken = 1'b0;

      case (state_q)
         ST_RUN, ST_IMISS: begin
            if (bus.dMiss) begin
               // Overrides a pending I-fill; the I-cache keeps the line and
               // the fetch misses again on return if it was not filled.
               ctrl    = ctrl_freeze(1'b1);
               state_d = ST_DMISS;
               timer_d = '0;
            end else if (bus.memPcSrc) begin
               ctrl.pc_sel       = 1'b1;
               ctrl.if_id_flush  = 1'b1;
               ctrl.id_ex_flush  = 1'b1;
               ctrl.ex_mem_flush = 1'b1;
               ctrl.i_abort      = (state_q == ST_IMISS);
               branch_taken      = 1'b1;
               state_d           = ST_RUN;
            end else begin
               // Miss tracking continues underneath a load-use bubble; only
               // the strobes are overridden by the higher-priority hazard.
               if (state_q == ST_IMISS) begin
                  ctrl.pc_write    = bus.iReady;
                  ctrl.if_id_flush = !bus.iReady;
                  if (bus.iReady) begin
                     state_d = ST_RUN;
                  end else begin
                     timer_d = timer_inc;
                     if (miss_expired) state_d = ST_ERR;
                  end
               end else if (bus.iMiss) begin
                  ctrl.pc_write    = 1'b0;
                  ctrl.if_id_flush = 1'b1;
                  state_d          = ST_IMISS;
                  timer_d          = '0;
               end
               if (load_use) begin
                  // Hold PC and if_id so the dependent instruction re-issues.
                  ctrl.pc_write    = 1'b0;
                  ctrl.if_id_write = 1'b0;
                  ctrl.if_id_flush = 1'b0;
                  ctrl.id_ex_flush = 1'b1;
               end
            end
         end
         ST_DMISS: begin
            // Branch in ex_mem is frozen with everything else and acts on exit.
            ctrl = ctrl_freeze(!bus.dReady);
            if (bus.dReady) begin
               state_d = ST_RUN;
            end else begin
               timer_d = timer_inc;
               if (miss_expired) state_d = ST_ERR;
            end
         end
         ST_ERR: begin
            ctrl = ctrl_halt();
         end
      endcase

      stall_cnt_d = stall_cnt_q;
      if (!ctrl.pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      flush_cnt_d = flush_cnt_q;
      if (branch_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   // Reset drives the halt pattern straight through, not waiting for an edge.
   assign ctrl_out = reset_n ? ctrl : ctrl_halt();

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_RUN;
         timer_q     <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.pcWrite    = ctrl_out.pc_write;
   assign bus.pcSel      = ctrl_out.pc_sel;
   assign bus.ifIdWrite  = ctrl_out.if_id_write;
   assign bus.ifIdFlush  = ctrl_out.if_id_flush;
   assign bus.idExWrite  = ctrl_out.id_ex_write;
   assign bus.idExFlush  = ctrl_out.id_ex_flush;
   assign bus.exMemWrite = ctrl_out.ex_mem_write;
   assign bus.exMemFlush = ctrl_out.ex_mem_flush;
   assign bus.memWbFlush = ctrl_out.mem_wb_flush;
   assign bus.iAbort     = ctrl_out.i_abort;
   assign bus.err        = (state_q == ST_ERR);
   assign bus.stallCnt   = stall_cnt_q;
   assign bus.flushCnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed scenarios with literal expectations, then randomized traffic
//   compared every cycle against a behavioural model of the sequencer.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

   localparam int TO   = 8;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   // {pcWrite,pcSel,ifIdW,ifIdF,idExW,idExF,exMemW,exMemF,memWbF,iAbort,err}
   localparam logic [10:0] V_RST = 11'b0_0_0_1_0_1_0_1_1_0_0;

   logic clock = 1'b0;
   logic reset_n;
   int   n_chk = 0;
   int   n_err = 0;

   pipeline_ctrl_if #(.CNT_W(CW)) bus ();

   pipeline_ctrl #(.MISS_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // mode: 0 running, 1 waiting for I-fill, 2 waiting for D-fill, 3 dead
   int m_mode = 0, m_wait = 0, m_stall = 0, m_flush = 0;

   always @(negedge clock) begin
      logic [10:0] act_v, exp_v;
      bit pw, ps, iw, ifl, ew, efl, mw, mfl, wbf, ab, er, lu, br;
      int nxt, wt;
      act_v = {bus.pcWrite, bus.pcSel, bus.ifIdWrite, bus.ifIdFlush, bus.idExWrite,
               bus.idExFlush, bus.exMemWrite, bus.exMemFlush, bus.memWbFlush,
               bus.iAbort, bus.err};
      if (!reset_n) begin
         check("model_reset_ctrl", 32'(act_v), 32'(V_RST));
         check("model_reset_cnt", {bus.stallCnt, bus.flushCnt}, 0);
         m_mode = 0; m_wait = 0; m_stall = 0; m_flush = 0;
      end else begin
         lu = bus.idExMemRead && (bus.idExRt != 0) &&
              (bus.idExRt == bus.ifIdRs || bus.idExRt == bus.ifIdRt);
         {pw, ps, iw, ifl, ew, efl, mw, mfl, wbf, ab, er} = 11'b1_0_1_0_1_0_1_0_0_0_0;
         nxt = m_mode; wt = m_wait; br = 0;
         if (m_mode == 3) begin
            {pw, ps, iw, ifl, ew, efl, mw, mfl, wbf, ab, er} = 11'b0_0_0_1_0_1_0_1_1_0_1;
         end else if (m_mode == 2 || bus.dMiss) begin
            pw = 0; iw = 0; ew = 0; mw = 0;
            wbf = !(m_mode == 2 && bus.dReady);
            if (m_mode != 2) begin nxt = 2; wt = 0; end
            else if (bus.dReady) nxt = 0;
            else begin wt = m_wait + 1; if (wt >= TO) nxt = 3; end
         end else if (bus.memPcSrc) begin
            ps = 1; ifl = 1; efl = 1; mfl = 1; ab = (m_mode == 1); nxt = 0; br = 1;
         end else begin
            if (m_mode == 1) begin
               pw = bus.iReady; ifl = !bus.iReady;
               if (bus.iReady) nxt = 0;
               else begin wt = m_wait + 1; if (wt >= TO) nxt = 3; end
            end else if (bus.iMiss) begin
               pw = 0; ifl = 1; nxt = 1; wt = 0;
            end
            if (lu) begin pw = 0; iw = 0; ifl = 0; efl = 1; end
         end
         exp_v = {pw, ps, iw, ifl, ew, efl, mw, mfl, wbf, ab, er};
         check("model_ctrl", 32'(act_v), 32'(exp_v));
         check("model_cnt", {bus.stallCnt, bus.flushCnt}, {m_stall[CW-1:0], m_flush[CW-1:0]});
         if (!pw && m_stall < CMAX) m_stall++;
         if (br && m_flush < CMAX) m_flush++;
         m_mode = nxt; m_wait = wt;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(); @(posedge clock); #1; endtask
   task automatic settle(); #2; endtask

   task automatic idle();
      bus.ifIdRs = 0; bus.ifIdRt = 0; bus.idExRt = 0; bus.idExMemRead = 0;
      bus.memPcSrc = 0; bus.dMiss = 0; bus.dReady = 0; bus.iMiss = 0; bus.iReady = 0;
   endtask

   task automatic do_reset();
      cyc(); reset_n = 0; idle();
      settle();
      check("rst_pcWrite", 32'(bus.pcWrite), 0);
      check("rst_ifIdFlush", 32'(bus.ifIdFlush), 1);
      check("rst_err", 32'(bus.err), 0);
      check("rst_cnts", {bus.stallCnt, bus.flushCnt}, 0);
      cyc(); cyc(); reset_n = 1;
   endtask

   initial begin
      reset_n = 0;
      idle();

      // 1: load-use bubble, and r0 never stalls
      do_reset();
      cyc(); bus.idExMemRead = 1; bus.idExRt = 5; bus.ifIdRs = 5;
      settle();
      check("lu_stall", {bus.pcWrite, bus.ifIdWrite, bus.idExFlush}, 3'b001);
      cyc(); idle();
      settle();
      check("lu_release", {bus.pcWrite, bus.ifIdWrite, bus.idExFlush}, 3'b110);
      cyc(); bus.idExMemRead = 1; bus.idExRt = 0; bus.ifIdRs = 0;
      settle();
      check("lu_r0", {bus.pcWrite, bus.ifIdWrite, bus.idExFlush}, 3'b110);

      // 2: D-miss with fill after 4 cycles
      do_reset();
      cyc(); bus.dMiss = 1;
      settle();
      check("dm_t0", {bus.pcWrite, bus.exMemWrite, bus.memWbFlush}, 3'b001);
      for (int i = 1; i <= 3; i++) begin
         cyc(); idle();
         settle();
         check("dm_frozen", {bus.pcWrite, bus.ifIdWrite, bus.memWbFlush}, 3'b001);
      end
      cyc(); bus.dReady = 1;
      settle();
      check("dm_ready", {bus.pcWrite, bus.exMemWrite, bus.memWbFlush}, 3'b000);
      cyc(); idle();
      settle();
      check("dm_run", {bus.pcWrite, bus.memWbFlush}, 2'b10);
      check("dm_stallCnt", 32'(bus.stallCnt), 5);

      // 3: branch during I-miss aborts the fill
      do_reset();
      cyc(); bus.iMiss = 1;
      settle();
      check("im_t0", {bus.pcWrite, bus.ifIdFlush}, 2'b01);
      cyc(); idle();
      cyc(); bus.memPcSrc = 1;
      settle();
      check("im_branch", {bus.pcWrite, bus.pcSel, bus.iAbort, bus.ifIdFlush,
                          bus.idExFlush, bus.exMemFlush}, 6'b111111);
      cyc(); idle();
      settle();
      check("im_run", {bus.pcWrite, bus.pcSel, bus.iAbort}, 3'b100);
      check("im_flushCnt", 32'(bus.flushCnt), 1);

      // 4: dMiss + branch + load-use together: only the freeze shows
      do_reset();
      cyc(); bus.dMiss = 1; bus.memPcSrc = 1; bus.idExMemRead = 1; bus.idExRt = 3; bus.ifIdRt = 3;
      settle();
      check("all_t0", {bus.pcWrite, bus.pcSel, bus.memWbFlush, bus.idExFlush, bus.exMemFlush}, 5'b00100);
      cyc(); bus.dMiss = 0; bus.idExMemRead = 0;
      settle();
      check("all_hold", {bus.pcSel, bus.memWbFlush}, 2'b01);
      cyc(); bus.dReady = 1;
      settle();
      check("all_ready", {bus.pcSel, bus.memWbFlush}, 2'b00);
      cyc(); bus.dReady = 0;
      settle();
      check("all_branch", {bus.pcWrite, bus.pcSel, bus.exMemFlush}, 3'b111);
      cyc(); idle();
      settle();
      check("all_cnts", {bus.stallCnt, bus.flushCnt}, {4'd3, 4'd1});

      // 5: timeout into sticky ERR, counter saturation, reset recovery
      do_reset();
      cyc(); bus.dMiss = 1;
      for (int i = 1; i <= 8; i++) begin cyc(); idle(); end
      settle();
      check("to_not_yet", 32'(bus.err), 0);
      cyc();
      settle();
      check("to_err", {bus.err, bus.pcWrite, bus.ifIdFlush, bus.memWbFlush}, 4'b1011);
      cyc(); bus.dReady = 1;
      settle();
      check("to_sticky", 32'(bus.err), 1);
      for (int i = 11; i <= 20; i++) begin cyc(); idle(); end
      settle();
      check("to_sat", 32'(bus.stallCnt), CMAX);
      do_reset();
      cyc();
      settle();
      check("to_recover", {bus.err, bus.pcWrite}, 2'b01);

      // 6: async reset between edges while frozen
      do_reset();
      cyc(); bus.dMiss = 1;
      cyc(); idle();
      settle();
      check("ar_pre", {bus.ifIdFlush, bus.memWbFlush, bus.stallCnt}, {1'b0, 1'b1, 4'd1});
      reset_n = 0;
      #1;
      check("ar_now", {bus.pcWrite, bus.ifIdFlush, bus.idExFlush, bus.exMemFlush, bus.stallCnt},
            {1'b0, 1'b1, 1'b1, 1'b1, 4'd0});
      cyc(); reset_n = 1;
      cyc();
      settle();
      check("ar_run", {bus.pcWrite, bus.memWbFlush}, 2'b10);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         cyc();
         if (!reset_n) reset_n = 1;
         else if ($urandom_range(0, 299) == 0) reset_n = 0;
         bus.ifIdRs      = 5'($urandom_range(0, 3));
         bus.ifIdRt      = 5'($urandom_range(0, 3));
         bus.idExRt      = 5'($urandom_range(0, 3));
         bus.idExMemRead = ($urandom_range(0, 9) < 3);
         bus.memPcSrc    = ($urandom_range(0, 9) == 0);
         bus.dMiss       = ($urandom_range(0, 19) == 0);
         bus.dReady      = ($urandom_range(0, 4) == 0);
         bus.iMiss       = ($urandom_range(0, 9) == 0);
         bus.iReady      = ($urandom_range(0, 4) == 0);
      end
      cyc(); idle();
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
